// File: rtl/irq_ctl.sv
// rtl/irq_ctl.sv - 8-source memory-mapped interrupt controller for the 65C02 bus
//
// Purpose:
//   Synchronizes 8 asynchronous sources, latches them into a pending register
//   (per-bit edge or level detection), applies a mask and drives a registered
//   irq. Exposes an 8-byte register window at BASE with one-cycle read latency.
//
// Optional feature:
//   IRQ_VECTOR_EN - adds VLO/VHI registers (offsets 5/6) and claims reads of
//   $FFFE/$FFFF, returning VLO | (id << 2) and VHI respectively.
//
// Ports:
//   clk    in   1  clock
//   reset  in   1  synchronous, active-high reset
//   AB     in  16  CPU address bus
//   WE     in   1  CPU write enable
//   DO     in   8  CPU write data
//   DB     out  8  registered read data (cycle after address)
//   sel    out  1  registered; high when DB carries this block's data
//   src    in   8  asynchronous interrupt sources, bit 0 highest priority
//   irq    out  1  registered interrupt request

module irq_ctl #(
  parameter logic [15:0] BASE = 16'hD000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] AB,
  input  logic        WE,
  input  logic [7:0]  DO,
  output logic [7:0]  DB,
  output logic        sel,
  input  logic [7:0]  src,
  output logic        irq
);

  logic [7:0] s1_q, s2_q, s3_q;
  logic [7:0] pending_q, pending_d;
  logic [7:0] mask_q, mask_d;
  logic [7:0] edge_q, edge_d;
  logic [7:0] db_q, db_d;
  logic       sel_q, sel_d;
  logic       irq_q, irq_d;
`ifdef IRQ_VECTOR_EN
  logic [7:0] vlo_q, vlo_d;
  logic [7:0] vhi_q, vhi_d;
`endif

  logic       win, wr, rd;
  logic [7:0] masked, w1c, w1s, edge_set, rdata;
  logic       any;
  logic [2:0] id;

  always_comb begin
    win    = (AB[15:3] == BASE[15:3]);
    wr     = win & WE;
    rd     = win & ~WE;
    masked = pending_q & mask_q;
    any    = |masked;

    // Scan from the top so the lowest-numbered set bit is the last to win.
    id = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (masked[i]) id = i[2:0];
    end

    w1c      = (wr && AB[2:0] == 3'd0) ? DO : 8'h00;
    w1s      = (wr && AB[2:0] == 3'd4) ? DO : 8'h00;
    edge_set = s2_q & ~s3_q;

    // Edge bits: sticky with W1C; set sources applied after the clear so a
    // same-cycle set wins. Level bits simply follow the synchronized source.
    pending_d = (edge_q & ((pending_q & ~w1c) | edge_set | w1s))
              | (~edge_q & s2_q);

    mask_d = (wr && AB[2:0] == 3'd1) ? DO : mask_q;
    edge_d = (wr && AB[2:0] == 3'd2) ? DO : edge_q;
`ifdef IRQ_VECTOR_EN
    vlo_d  = (wr && AB[2:0] == 3'd5) ? DO : vlo_q;
    vhi_d  = (wr && AB[2:0] == 3'd6) ? DO : vhi_q;
`endif

    irq_d = any;

    rdata = 8'h00;
    case (AB[2:0])
      3'd0:    rdata = masked;
      3'd1:    rdata = mask_q;
      3'd2:    rdata = edge_q;
      3'd3:    rdata = {any, 4'b0000, id};
`ifdef IRQ_VECTOR_EN
      3'd5:    rdata = vlo_q;
      3'd6:    rdata = vhi_q;
`endif
      default: rdata = 8'h00;
    endcase

    db_d  = 8'h00;
    sel_d = 1'b0;
    if (rd) begin
      db_d  = rdata;
      sel_d = 1'b1;
    end
`ifdef IRQ_VECTOR_EN
    // Vector fetch takes precedence in case the window overlaps $FFF8.
    if (!WE && AB == 16'hFFFE) begin
      db_d  = vlo_q | {3'b000, id, 2'b00};
      sel_d = 1'b1;
    end else if (!WE && AB == 16'hFFFF) begin
      db_d  = vhi_q;
      sel_d = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q      <= 8'h00;
      s2_q      <= 8'h00;
      s3_q      <= 8'h00;
      pending_q <= 8'h00;
      mask_q    <= 8'h00;
      edge_q    <= 8'h00;
      db_q      <= 8'h00;
      sel_q     <= 1'b0;
      irq_q     <= 1'b0;
`ifdef IRQ_VECTOR_EN
      vlo_q     <= 8'h00;
      vhi_q     <= 8'h00;
`endif
    end else begin
      s1_q      <= src;
      s2_q      <= s1_q;
      s3_q      <= s2_q;
      pending_q <= pending_d;
      mask_q    <= mask_d;
      edge_q    <= edge_d;
      db_q      <= db_d;
      sel_q     <= sel_d;
      irq_q     <= irq_d;
`ifdef IRQ_VECTOR_EN
      vlo_q     <= vlo_d;
      vhi_q     <= vhi_d;
`endif
    end
  end

  assign DB  = db_q;
  assign sel = sel_q;
  assign irq = irq_q;

endmodule
